// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are latched at start; the result is computed from them and committed when the counter expires.
module mdu_hilo #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int DW      = 2 * WIDTH;

    localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Decoded view of the latched operation
    logic op_signed, op_is_div, op_is_acc, op_is_sub;

    assign op_signed = ~op_q[0];
    assign op_is_div = (op_q[2:1] == 2'b01);
    assign op_is_acc = op_q[2];
    assign op_is_sub = op_q[2] & op_q[1];

    // Multiply: the low 2*WIDTH bits of a product of sign- or zero-extended operands
    // equal the signed or unsigned full product.
    logic [DW-1:0] a_ext, b_ext, prod, acc, mul_res;

    always_comb begin
        a_ext   = op_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext   = op_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod    = a_ext * b_ext;
        acc     = {hi_q, lo_q};
        mul_res = prod;
        if (op_is_acc) begin
            mul_res = op_is_sub ? (acc - prod) : (acc + prod);
        end
    end

    // Divide on magnitudes, then restore signs; -2^(W-1)/-1 wraps to itself with remainder 0.
    logic             a_neg, b_neg, div_zero;
    logic [WIDTH-1:0] a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

    always_comb begin
        a_neg    = op_signed & a_q[WIDTH-1];
        b_neg    = op_signed & b_q[WIDTH-1];
        a_mag    = a_neg ? (-a_q) : a_q;
        b_mag    = b_neg ? (-b_q) : b_q;
        div_zero = (b_q == '0);
        divisor  = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag    = a_mag / divisor;
        r_mag    = a_mag % divisor;
        quot     = (a_neg ^ b_neg) ? (-q_mag) : q_mag;
        rem      = a_neg ? (-r_mag) : r_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = (op[2:1] == 2'b01) ? DIV_N : MULT_N;
                    state_d = ST_RUN;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            default: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    if (op_is_div) begin
                        if (!div_zero) begin
                            hi_d = rem;
                            lo_d = quot;
                        end
                    end else begin
                        {hi_d, lo_d} = mul_res;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: vector table, hand-written corner sequences and randomized ops against a reference model.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    mdu_hilo #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          pre;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input bit hw, input bit lw, input logic [31:0] d);
        hi_we = hw; lo_we = lw; wdata = d;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    // Launch an op and count busy cycles; optional noise scrambles the operand inputs meanwhile.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit noise, output int cyc);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            if (noise) begin
                a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
            end
            tick();
        end
    endtask

    // Reference model: plain spec arithmetic on {hi,lo}.
    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                           input logic [31:0] y, input logic [63:0] accv);
        int          sx, sy, q, r;
        longint      sp;
        logic [63:0] up;
        sx = x; sy = y;
        sp = longint'(sx) * longint'(sy);
        up = {32'h0, x} * {32'h0, y};
        case (o)
            3'd0: return sp;
            3'd1: return up;
            3'd2: begin
                if (y == 0) return accv;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
                q = sx / sy; r = sx % sy;
                return {r, q};
            end
            3'd3: begin
                if (y == 0) return accv;
                return {x % y, x / y};
            end
            3'd4: return accv + sp;
            3'd5: return accv + up;
            3'd6: return accv - sp;
            default: return accv - up;
        endcase
    endfunction

    initial begin
        int cyc;
        logic [63:0] model;
        logic [31:0] saved_lo;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'h3, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFE, 32'h3, 1'b0, 32'h0, 32'h0, 32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h2, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{3'd3, 32'h7, 32'h0, 1'b1, 32'h11, 32'h22, 32'h11, 32'h22, 10};
        vecs[4]  = '{3'd4, 32'h1_0000, 32'h1_0000, 1'b1, 32'h0, 32'h1, 32'h1, 32'h1, 5};
        vecs[5]  = '{3'd7, 32'h1, 32'h2, 1'b0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 5};
        vecs[6]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_0000, 10};
        vecs[7]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h1, 5};
        vecs[8]  = '{3'd6, 32'h2, 32'h3, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[9]  = '{3'd3, 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0, 32'h0, 32'hF, 32'h0FFF_FFFF, 10};
        vecs[10] = '{3'd2, 32'h7, 32'hFFFF_FFFE, 1'b0, 32'h0, 32'h0, 32'h1, 32'hFFFF_FFFD, 10};
        vecs[11] = '{3'd5, 32'h1, 32'h1, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5};

        // Reset then three idle cycles
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check("reset_hi", {32'h0, hi}, 64'h0);
        check("reset_lo", {32'h0, lo}, 64'h0);
        check("reset_busy", {63'h0, busy}, 64'h0);
        $display("txn reset idle hi=%h lo=%h busy=%b", hi, lo, busy);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].pre) begin
                do_write(1'b1, 1'b0, vecs[i].pre_hi);
                do_write(1'b0, 1'b1, vecs[i].pre_lo);
                check($sformatf("v%0d_mthi_mtlo", i), {hi, lo}, {vecs[i].pre_hi, vecs[i].pre_lo});
            end
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, cyc);
            check($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cyc));
            check($sformatf("v%0d_hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
            $display("txn vec%0d op=%0d a=%h b=%h cyc=%0d hi=%h lo=%h", i, vecs[i].op,
                     vecs[i].a, vecs[i].b, cyc, hi, lo);
        end

        // Start and lo_we pulsed during busy: ignored, first op timing/result intact
        do_write(1'b0, 1'b1, 32'h5A5A_5A5A);
        start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFE; b = 32'h3;
        tick();
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd3; lo_we = 1'b1; wdata = 32'h99;
            if (busy) cyc++;
            tick();
        end
        start = 1'b0; lo_we = 1'b0;
        check("busy_lo_we_ignored", {32'h0, lo}, {32'h0, 32'h5A5A_5A5A});
        while (busy && cyc < 200) begin
            cyc++;
            tick();
        end
        check("restart_cycles", 64'(cyc), 64'd5);
        check("restart_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        tick();
        check("restart_no_queue", {63'h0, busy}, 64'h0);
        $display("txn start-during-busy cyc=%0d hi=%h lo=%h", cyc, hi, lo);

        // Start and hi_we on the same idle edge: start wins
        do_write(1'b1, 1'b0, 32'h44);
        start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; hi_we = 1'b0;
        check("start_wins_hi_kept", {32'h0, hi}, 64'h44);
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            tick();
        end
        check("start_wins_result", {hi, lo}, 64'h6);
        $display("txn start+hi_we hi=%h lo=%h", hi, lo);

        // Both strobes together
        do_write(1'b1, 1'b1, 32'hCAFE_F00D);
        check("both_we", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);
        $display("txn mthi+mtlo hi=%h lo=%h", hi, lo);

        // Asynchronous reset in the middle of a division
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", {63'h0, busy}, 64'h0);
        check("async_rst_hilo", {hi, lo}, 64'h0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        check("async_rst_no_write", {hi, lo}, 64'h0);
        check("async_rst_idle", {63'h0, busy}, 64'h0);
        $display("txn reset-mid-div hi=%h lo=%h busy=%b", hi, lo, busy);

        // Randomized ops against the reference model
        model = 64'h0;
        for (int t = 0; t < 150; t++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                wdata = $urandom;
                do_write(1'b1, 1'b0, wdata);
                model[63:32] = wdata;
            end else if (sel == 1) begin
                wdata = $urandom;
                do_write(1'b0, 1'b1, wdata);
                model[31:0] = wdata;
            end
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            model = ref_op(ro, ra, rb, model);
            run_op(ro, ra, rb, 1'b1, cyc);
            check($sformatf("rnd%0d_cycles", t), 64'(cyc), (ro[2:1] == 2'b01) ? 64'd10 : 64'd5);
            check($sformatf("rnd%0d_hilo", t), {hi, lo}, model);
            $display("txn rnd%0d op=%0d a=%h b=%h hi=%h lo=%h", t, ro, ra, rb, hi, lo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
